toggle_port_responder: RTL

Memory-side responder for the toggle request/acknowledge port protocol. The ROM download controller and the CPU ports use this protocol to drive SDRAM ports. The block accepts one request per `port_req` toggle and latches its address, byte strobes, data and direction. It then runs a single access on a simple ready/valid memory backend, returns read data, and answers by toggling `port_ack`. It lets the toggle protocol be reused in front of BRAM or an SDRAM controller, and it gives a bench-visible reference responder for the download path.

---
 rtl/toggle_port_responder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/toggle_port_responder.sv
// Toggle request/acknowledge port responder that runs one access per request on a ready/valid memory backend.
// Optional write readback check is compiled in with TOGGLE_RESP_READBACK_EN.
module toggle_port_responder #(
    parameter int unsigned AW      = 23,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              port_req,
    output logic              port_ack,
    input  logic [AW-1:0]     port_a,
    input  logic [DW/8-1:0]   port_ds,
    input  logic              port_we,
    input  logic [DW-1:0]     port_d,
    output logic [DW-1:0]     port_q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_a,
    output logic [DW/8-1:0]   mem_be,
    output logic [DW-1:0]     mem_d,
    input  logic              mem_ready,
    input  logic [DW-1:0]     mem_q,
    input  logic              mem_qv,
    output logic              busy,
    output logic              err_timeout,
    output logic [7:0]        err_count
);
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_ACK      = 3'd3;
`ifdef TOGGLE_RESP_READBACK_EN
    localparam logic [2:0] S_RB_ISSUE = 3'd4;
    localparam logic [2:0] S_RB_WAIT  = 3'd5;
`endif

    logic [2:0]    state, state_nxt;
    logic [AW-1:0] lat_a, lat_a_nxt;
    logic [BW-1:0] lat_ds, lat_ds_nxt;
    logic          lat_we, lat_we_nxt;
    logic [DW-1:0] lat_d, lat_d_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] rd_buf, rd_buf_nxt;
    logic          port_ack_nxt;
    logic [DW-1:0] port_q_nxt;
    logic          mem_req_nxt, mem_we_nxt;
    logic [AW-1:0] mem_a_nxt;
    logic [BW-1:0] mem_be_nxt;
    logic [DW-1:0] mem_d_nxt;
    logic          err_timeout_nxt;

`ifdef TOGGLE_RESP_READBACK_EN
    logic [7:0]    err_count_nxt;
    logic [DW-1:0] rb_mask;
    logic          rb_mismatch;

    // Compare only the byte lanes the write actually touched.
    always_comb begin
        rb_mask = '0;
        for (int i = 0; i < int'(BW); i++) begin
            rb_mask[i*8 +: 8] = {8{lat_ds[i]}};
        end
        rb_mismatch = |((mem_q ^ lat_d) & rb_mask);
    end
`else
    assign err_count = 8'd0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        lat_a_nxt       = lat_a;
        lat_ds_nxt      = lat_ds;
        lat_we_nxt      = lat_we;
        lat_d_nxt       = lat_d;
        cnt_nxt         = cnt;
        rd_buf_nxt      = rd_buf;
        port_ack_nxt    = port_ack;
        port_q_nxt      = port_q;
        mem_req_nxt     = 1'b0;
        mem_we_nxt      = 1'b0;
        mem_a_nxt       = '0;
        mem_be_nxt      = '0;
        mem_d_nxt       = '0;
        err_timeout_nxt = err_timeout;
`ifdef TOGGLE_RESP_READBACK_EN
        err_count_nxt   = err_count;
`endif
        case (state)
            S_IDLE: begin
                if (port_req != port_ack) begin
                    lat_a_nxt  = port_a;
                    lat_ds_nxt = port_ds;
                    lat_we_nxt = port_we;
                    lat_d_nxt  = port_d;
                    cnt_nxt    = CW'(TIMEOUT);
                    state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lat_we && (lat_ds == '0)) begin
                    state_nxt = S_ACK;
                end else if (mem_req && mem_ready) begin
                    cnt_nxt = CW'(TIMEOUT);
`ifdef TOGGLE_RESP_READBACK_EN
                    state_nxt = lat_we ? S_RB_ISSUE : S_WAIT;
`else
                    state_nxt = lat_we ? S_ACK : S_WAIT;
`endif
                end else if (cnt == '0) begin
                    err_timeout_nxt = 1'b1;
                    rd_buf_nxt      = '1;
                    state_nxt       = S_ACK;
                end else begin
                    cnt_nxt     = cnt - CW'(1);
                    mem_req_nxt = 1'b1;
                    mem_we_nxt  = lat_we;
                    mem_a_nxt   = lat_a;
                    mem_be_nxt  = lat_we ? lat_ds : '1;
                    mem_d_nxt   = lat_d;
                end
            end
            S_WAIT: begin
                if (mem_qv) begin
                    rd_buf_nxt = mem_q;
                    state_nxt  = S_ACK;
                end else if (cnt == '0) begin
                    err_timeout_nxt = 1'b1;
                    rd_buf_nxt      = '1;
                    state_nxt       = S_ACK;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_ACK: begin
                // Read data and the ack toggle become visible on the same edge.
                port_ack_nxt = ~port_ack;
                if (!lat_we) begin
                    port_q_nxt = rd_buf;
                end
                state_nxt = S_IDLE;
            end
`ifdef TOGGLE_RESP_READBACK_EN
            S_RB_ISSUE: begin
                if (mem_req && mem_ready) begin
                    cnt_nxt   = CW'(TIMEOUT);
                    state_nxt = S_RB_WAIT;
                end else if (cnt == '0) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = S_ACK;
                end else begin
                    cnt_nxt     = cnt - CW'(1);
                    mem_req_nxt = 1'b1;
                    mem_a_nxt   = lat_a;
                    mem_be_nxt  = '1;
                end
            end
            S_RB_WAIT: begin
                if (mem_qv) begin
                    if (rb_mismatch && (err_count != 8'hFF)) begin
                        err_count_nxt = err_count + 8'd1;
                    end
                    state_nxt = S_ACK;
                end else if (cnt == '0) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = S_ACK;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_IDLE;
            lat_a       <= '0;
            lat_ds      <= '0;
            lat_we      <= 1'b0;
            lat_d       <= '0;
            cnt         <= '0;
            rd_buf      <= '0;
            port_ack    <= 1'b0;
            port_q      <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_a       <= '0;
            mem_be      <= '0;
            mem_d       <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
`ifdef TOGGLE_RESP_READBACK_EN
            err_count   <= 8'd0;
`endif
        end else begin
            state       <= state_nxt;
            lat_a       <= lat_a_nxt;
            lat_ds      <= lat_ds_nxt;
            lat_we      <= lat_we_nxt;
            lat_d       <= lat_d_nxt;
            cnt         <= cnt_nxt;
            rd_buf      <= rd_buf_nxt;
            port_ack    <= port_ack_nxt;
            port_q      <= port_q_nxt;
            mem_req     <= mem_req_nxt;
            mem_we      <= mem_we_nxt;
            mem_a       <= mem_a_nxt;
            mem_be      <= mem_be_nxt;
            mem_d       <= mem_d_nxt;
            busy        <= (state_nxt != S_IDLE);
            err_timeout <= err_timeout_nxt;
`ifdef TOGGLE_RESP_READBACK_EN
            err_count   <= err_count_nxt;
`endif
        end
    end

endmodule
